// File: rtl/pdp8_pkg.sv
// rtl/pdp8_pkg.sv - shared PDP-8 types for decoder and execute stage
package pdp8_pkg;

    localparam int              PDP_AW         = 12;
    localparam int              PDP_DW         = 12;
    localparam logic [11:0]     PDP_START_ADDR = 12'o0200;

    // Memory-reference instruction: one-hot opcode plus the resolved effective address
    typedef struct packed {
        logic        op_and;
        logic        op_tad;
        logic        op_isz;
        logic        op_dca;
        logic        op_jms;
        logic        op_jmp;
        logic [11:0] ea;
    } pdp_mem_opcode_s;

    // Operate (group 7) instruction: one-hot microinstruction bits
    typedef struct packed {
        logic iac;
        logic ral;
        logic rtl;
        logic rar;
        logic rtr;
        logic cml;
        logic cma;
        logic cia;
        logic cll;
        logic cla1;
        logic cla2;
        logic cla_cll;
        logic osr;
        logic skp;
        logic snl;
        logic szl;
        logic sza;
        logic sna;
        logic sma;
        logic spa;
        logic hlt;
    } pdp_op7_opcode_s;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXEC,
        ST_RD,
        ST_RD_WAIT,
        ST_WR,
        ST_HALTED,
        ST_DONE
    } exec_state_e;

    // Six MRI bits plus 21 op7 bits
    localparam int OPC_BITS = 27;

    // True when more than one opcode bit is set
    function automatic logic multi_hot(input logic [OPC_BITS-1:0] v);
        return (v & (v - OPC_BITS'(1))) != '0;
    endfunction

endpackage

// File: rtl/pdp8_op7_alu.sv
// rtl/pdp8_op7_alu.sv - combinational group-7 operate microinstruction unit
module pdp8_op7_alu
    import pdp8_pkg::*;
#(
    parameter int DW = 12
) (
    input  pdp_op7_opcode_s i_op7,
    input  logic [DW-1:0]   i_ac,
    input  logic            i_link,
    input  logic [DW-1:0]   i_switch,
    output logic [DW-1:0]   o_ac,
    output logic            o_link,
    output logic            o_skip,
    output logic            o_halt
);

    logic [DW:0] w_x;
    logic [DW:0] w_inc;
    logic [DW:0] w_neg;
    logic        w_zero;

    // Rotates treat {L,AC} as one 13-bit word
    assign w_x    = {i_link, i_ac};
    assign w_inc  = {1'b0, i_ac} + {{DW{1'b0}}, 1'b1};
    assign w_neg  = {1'b0, ~i_ac} + {{DW{1'b0}}, 1'b1};
    assign w_zero = (i_ac == '0);

    // Apply the single selected microinstruction; skip tests see pre-instruction AC/L
    always_comb begin
        o_ac   = i_ac;
        o_link = i_link;
        o_skip = 1'b0;
        o_halt = 1'b0;
        if (i_op7.iac) begin
            o_ac   = w_inc[DW-1:0];
            o_link = i_link ^ w_inc[DW];
        end else if (i_op7.ral) begin
            {o_link, o_ac} = {w_x[DW-1:0], w_x[DW]};
        end else if (i_op7.rtl) begin
            {o_link, o_ac} = {w_x[DW-2:0], w_x[DW:DW-1]};
        end else if (i_op7.rar) begin
            {o_link, o_ac} = {w_x[0], w_x[DW:1]};
        end else if (i_op7.rtr) begin
            {o_link, o_ac} = {w_x[1:0], w_x[DW:2]};
        end else if (i_op7.cml) begin
            o_link = ~i_link;
        end else if (i_op7.cma) begin
            o_ac = ~i_ac;
        end else if (i_op7.cia) begin
            o_ac   = w_neg[DW-1:0];
            o_link = i_link ^ w_neg[DW];
        end else if (i_op7.cll) begin
            // Link cleared first, then rotated left into AC bit 0
            {o_link, o_ac} = {i_ac, 1'b0};
        end else if (i_op7.cla1 || i_op7.cla2) begin
            o_ac = '0;
        end else if (i_op7.cla_cll) begin
            o_ac   = '0;
            o_link = 1'b0;
        end else if (i_op7.osr) begin
            o_ac = i_ac | i_switch;
        end else if (i_op7.skp) begin
            o_skip = 1'b1;
        end else if (i_op7.snl) begin
            o_skip = i_link;
        end else if (i_op7.szl) begin
            o_skip = ~i_link;
        end else if (i_op7.sza) begin
            o_skip = w_zero;
        end else if (i_op7.sna) begin
            o_skip = ~w_zero;
        end else if (i_op7.sma) begin
            o_skip = i_ac[DW-1];
        end else if (i_op7.spa) begin
            o_skip = ~i_ac[DW-1];
        end else if (i_op7.hlt) begin
            o_halt = 1'b1;
        end
    end

endmodule

// File: rtl/pdp8_instr_exec.sv
// rtl/pdp8_instr_exec.sv - PDP-8 execute stage: AC/L/PC update and memory sequencing
module pdp8_instr_exec
    import pdp8_pkg::*;
#(
    parameter int             AW         = 12,
    parameter int             DW         = 12,
    parameter logic [AW-1:0]  START_ADDR = 12'o0200
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            dec_valid,
    output logic            dec_ready,
    input  pdp_mem_opcode_s mem_opcode,
    input  pdp_op7_opcode_s op7_opcode,
    input  logic [DW-1:0]   switch_reg,
    input  logic            resume,
    output logic            rd_req,
    output logic [AW-1:0]   rd_addr,
    input  logic [DW-1:0]   rd_data,
    output logic            wr_req,
    output logic [AW-1:0]   wr_addr,
    output logic [DW-1:0]   wr_data,
    output logic [AW-1:0]   pc_value,
    output logic            exec_done,
    output logic [DW-1:0]   ac_out,
    output logic            link_out,
    output logic            halted,
    output logic            illegal_op
);

    exec_state_e     r_state;
    pdp_op7_opcode_s r_op7;
    logic [AW-1:0]   r_ea;
    logic            r_is_and;
    logic            r_is_tad;
    logic            r_is_dca;
    logic [AW-1:0]   r_pc;
    logic [AW-1:0]   r_next_pc;
    logic [DW-1:0]   r_ac;
    logic            r_link;
    logic            r_dec_ready;
    logic            r_rd_req;
    logic [AW-1:0]   r_rd_addr;
    logic            r_wr_req;
    logic [AW-1:0]   r_wr_addr;
    logic [DW-1:0]   r_wr_data;
    logic            r_exec_done;
    logic            r_halted;
    logic            r_illegal;

    logic [5:0]      w_mri_bits;
    logic            w_illegal;
    logic            w_is_read;
    logic [AW-1:0]   w_ea_in;
    logic [AW-1:0]   w_pc_inc1;
    logic [AW-1:0]   w_pc_inc2;
    logic [DW-1:0]   w_isz_tmp;
    logic [DW:0]     w_tad_sum;
    logic [DW-1:0]   w_alu_ac;
    logic            w_alu_link;
    logic            w_alu_skip;
    logic            w_alu_halt;

    assign w_mri_bits = {mem_opcode.op_and, mem_opcode.op_tad, mem_opcode.op_isz,
                         mem_opcode.op_dca, mem_opcode.op_jms, mem_opcode.op_jmp};
    assign w_illegal  = multi_hot({w_mri_bits, op7_opcode});
    assign w_is_read  = mem_opcode.op_and | mem_opcode.op_tad | mem_opcode.op_isz;
    assign w_ea_in    = AW'(mem_opcode.ea);
    assign w_pc_inc1  = r_pc + AW'(1);
    assign w_pc_inc2  = r_pc + AW'(2);
    assign w_isz_tmp  = rd_data + DW'(1);
    assign w_tad_sum  = {1'b0, r_ac} + {1'b0, rd_data};

    pdp8_op7_alu #(
        .DW (DW)
    ) u_op7_alu (
        .i_op7    (r_op7),
        .i_ac     (r_ac),
        .i_link   (r_link),
        .i_switch (switch_reg),
        .o_ac     (w_alu_ac),
        .o_link   (w_alu_link),
        .o_skip   (w_alu_skip),
        .o_halt   (w_alu_halt)
    );

    // Execute FSM with architectural registers and registered handshake/memory outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_op7       <= '0;
            r_ea        <= '0;
            r_is_and    <= 1'b0;
            r_is_tad    <= 1'b0;
            r_is_dca    <= 1'b0;
            r_pc        <= START_ADDR;
            r_next_pc   <= START_ADDR;
            r_ac        <= '0;
            r_link      <= 1'b0;
            r_dec_ready <= 1'b1;
            r_rd_req    <= 1'b0;
            r_rd_addr   <= '0;
            r_wr_req    <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_exec_done <= 1'b0;
            r_halted    <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            r_rd_req    <= 1'b0;
            r_wr_req    <= 1'b0;
            r_exec_done <= 1'b0;
            r_illegal   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (dec_valid) begin
                        r_dec_ready <= 1'b0;
                        r_ea        <= w_ea_in;
                        r_is_and    <= mem_opcode.op_and;
                        r_is_tad    <= mem_opcode.op_tad;
                        r_is_dca    <= mem_opcode.op_dca;
                        r_op7       <= op7_opcode;
                        r_next_pc   <= w_pc_inc1;
                        if (w_illegal) begin
                            // Clearing the captured op7 bits turns EXEC into a NOP
                            r_illegal <= 1'b1;
                            r_op7     <= '0;
                            r_state   <= ST_EXEC;
                        end else if (w_is_read) begin
                            r_rd_req  <= 1'b1;
                            r_rd_addr <= w_ea_in;
                            r_state   <= ST_RD;
                        end else if (mem_opcode.op_dca) begin
                            r_wr_req  <= 1'b1;
                            r_wr_addr <= w_ea_in;
                            r_wr_data <= r_ac;
                            r_state   <= ST_WR;
                        end else if (mem_opcode.op_jms) begin
                            r_wr_req  <= 1'b1;
                            r_wr_addr <= w_ea_in;
                            r_wr_data <= DW'(w_pc_inc1);
                            r_next_pc <= w_ea_in + AW'(1);
                            r_state   <= ST_WR;
                        end else begin
                            if (mem_opcode.op_jmp) begin
                                r_next_pc <= w_ea_in;
                            end
                            r_state <= ST_EXEC;
                        end
                    end
                end
                ST_RD: begin
                    r_state <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    if (r_is_and) begin
                        r_ac    <= r_ac & rd_data;
                        r_state <= ST_DONE;
                    end else if (r_is_tad) begin
                        r_ac    <= w_tad_sum[DW-1:0];
                        r_link  <= r_link ^ w_tad_sum[DW];
                        r_state <= ST_DONE;
                    end else begin
                        // ISZ: write back the incremented word, skip when it wrapped to zero
                        r_wr_req  <= 1'b1;
                        r_wr_addr <= r_ea;
                        r_wr_data <= w_isz_tmp;
                        if (w_isz_tmp == '0) begin
                            r_next_pc <= w_pc_inc2;
                        end
                        r_state <= ST_WR;
                    end
                end
                ST_WR: begin
                    if (r_is_dca) begin
                        r_ac <= '0;
                    end
                    r_state <= ST_DONE;
                end
                ST_EXEC: begin
                    r_ac   <= w_alu_ac;
                    r_link <= w_alu_link;
                    if (w_alu_skip) begin
                        r_next_pc <= w_pc_inc2;
                    end
                    if (w_alu_halt) begin
                        r_halted <= 1'b1;
                        r_state  <= ST_HALTED;
                    end else begin
                        r_state <= ST_DONE;
                    end
                end
                ST_HALTED: begin
                    if (resume) begin
                        r_halted <= 1'b0;
                        r_state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_pc        <= r_next_pc;
                    r_exec_done <= 1'b1;
                    r_dec_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign dec_ready  = r_dec_ready;
    assign rd_req     = r_rd_req;
    assign rd_addr    = r_rd_addr;
    assign wr_req     = r_wr_req;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign pc_value   = r_pc;
    assign exec_done  = r_exec_done;
    assign ac_out     = r_ac;
    assign link_out   = r_link;
    assign halted     = r_halted;
    assign illegal_op = r_illegal;

endmodule

// File: tb/tb_pdp8_instr_exec.sv
// tb/tb_pdp8_instr_exec.sv - self-checking bench for the PDP-8 execute stage
module tb_pdp8_instr_exec;
    import pdp8_pkg::*;

    localparam int M_AND = 0, M_TAD = 1, M_ISZ = 2, M_DCA = 3, M_JMS = 4, M_JMP = 5;
    localparam int K_IAC = 0, K_RAL = 1, K_RTL = 2, K_RAR = 3, K_RTR = 4, K_CML = 5,
                   K_CMA = 6, K_CIA = 7, K_CLL = 8, K_CLA1 = 9, K_CLA2 = 10,
                   K_CLA_CLL = 11, K_OSR = 12, K_SKP = 13, K_SNL = 14, K_SZL = 15,
                   K_SZA = 16, K_SNA = 17, K_SMA = 18, K_SPA = 19, K_HLT = 20;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            dec_valid = 1'b0;
    logic            dec_ready;
    pdp_mem_opcode_s mem_opcode = '0;
    pdp_op7_opcode_s op7_opcode = '0;
    logic [11:0]     switch_reg = 12'o0070;
    logic            resume = 1'b0;
    logic            rd_req;
    logic [11:0]     rd_addr;
    logic [11:0]     rd_data = '0;
    logic            wr_req;
    logic [11:0]     wr_addr;
    logic [11:0]     wr_data;
    logic [11:0]     pc_value;
    logic            exec_done;
    logic [11:0]     ac_out;
    logic            link_out;
    logic            halted;
    logic            illegal_op;

    int checks = 0;
    int errors = 0;

    logic [11:0] mem [0:4095];
    logic [11:0] exp_wr_addr[$], exp_wr_data[$];
    logic [11:0] obs_wr_addr[$], obs_wr_data[$];
    logic [11:0] sb_pc[$], sb_ac[$];
    logic        sb_l[$];
    int          sb_lat[$];
    int          conflicts = 0;
    int          illegal_cnt = 0;
    int          rd_cnt = 0;

    pdp8_instr_exec #(.AW(12), .DW(12), .START_ADDR(12'o0200)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .dec_valid  (dec_valid),
        .dec_ready  (dec_ready),
        .mem_opcode (mem_opcode),
        .op7_opcode (op7_opcode),
        .switch_reg (switch_reg),
        .resume     (resume),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .pc_value   (pc_value),
        .exec_done  (exec_done),
        .ac_out     (ac_out),
        .link_out   (link_out),
        .halted     (halted),
        .illegal_op (illegal_op)
    );

    always #5 clk = ~clk;

    // Memory model: write commits at the edge, read data valid the cycle after rd_req
    always @(posedge clk) begin
        if (wr_req) mem[wr_addr] = wr_data;
        rd_data <= mem[rd_addr];
    end

    // Bus monitor
    always @(negedge clk) begin
        if (wr_req) begin
            obs_wr_addr.push_back(wr_addr);
            obs_wr_data.push_back(wr_data);
        end
        if (rd_req && wr_req) conflicts++;
        if (illegal_op) illegal_cnt++;
        if (rd_req) rd_cnt++;
    end

    function automatic pdp_mem_opcode_s mri(input int k, input logic [11:0] ea);
        pdp_mem_opcode_s v;
        v = '0;
        v.ea = ea;
        case (k)
            M_AND: v.op_and = 1'b1;
            M_TAD: v.op_tad = 1'b1;
            M_ISZ: v.op_isz = 1'b1;
            M_DCA: v.op_dca = 1'b1;
            M_JMS: v.op_jms = 1'b1;
            default: v.op_jmp = 1'b1;
        endcase
        return v;
    endfunction

    // Field iac is the MSB of the packed struct, hlt the LSB
    function automatic pdp_op7_opcode_s op7(input int k);
        logic [20:0] b;
        b = 21'd1 << (20 - k);
        return pdp_op7_opcode_s'(b);
    endfunction

    task automatic push_wr(input logic [11:0] a, input logic [11:0] d);
        exp_wr_addr.push_back(a);
        exp_wr_data.push_back(d);
    endtask

    task automatic run_instr(input pdp_mem_opcode_s m, input pdp_op7_opcode_s o,
                             input logic [11:0] e_pc, input logic [11:0] e_ac,
                             input logic e_l, input int e_lat, input string name);
        int cyc;
        bit seen;
        logic [11:0] p_pc, p_ac, ea, ed;
        logic p_l;
        int p_lat;
        sb_pc.push_back(e_pc);
        sb_ac.push_back(e_ac);
        sb_l.push_back(e_l);
        sb_lat.push_back(e_lat);
        @(negedge clk);
        checks++;
        if (dec_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_before got %0b want 1", name, dec_ready);
        end
        mem_opcode = m;
        op7_opcode = o;
        dec_valid  = 1'b1;
        @(negedge clk);
        dec_valid  = 1'b0;
        mem_opcode = '0;
        op7_opcode = '0;
        checks++;
        if (dec_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s ready_after_accept got %0b want 0", name, dec_ready);
        end
        seen = 1'b0;
        for (cyc = 0; cyc < 20; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (exec_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        p_pc = sb_pc.pop_front();
        p_ac = sb_ac.pop_front();
        p_l = sb_l.pop_front();
        p_lat = sb_lat.pop_front();
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s done_timeout got none want exec_done", name);
        end else begin
            if (cyc != p_lat) begin
                errors++;
                $display("FAIL %s latency got %0d want %0d", name, cyc, p_lat);
            end
            checks++;
            if (pc_value !== p_pc) begin
                errors++;
                $display("FAIL %s pc got %o want %o", name, pc_value, p_pc);
            end
            checks++;
            if (ac_out !== p_ac || link_out !== p_l) begin
                errors++;
                $display("FAIL %s ac_link got %o/%0b want %o/%0b", name, ac_out, link_out, p_ac, p_l);
            end
            checks++;
            if (dec_ready !== 1'b1) begin
                errors++;
                $display("FAIL %s ready_at_done got %0b want 1", name, dec_ready);
            end
        end
        checks++;
        if (obs_wr_addr.size() != exp_wr_addr.size()) begin
            errors++;
            $display("FAIL %s write_count got %0d want %0d", name, obs_wr_addr.size(), exp_wr_addr.size());
        end
        while (obs_wr_addr.size() > 0 && exp_wr_addr.size() > 0) begin
            ea = exp_wr_addr.pop_front();
            ed = exp_wr_data.pop_front();
            checks++;
            if (obs_wr_addr[0] !== ea || obs_wr_data[0] !== ed) begin
                errors++;
                $display("FAIL %s write got %o@%o want %o@%o", name, obs_wr_data[0], obs_wr_addr[0], ed, ea);
            end
            void'(obs_wr_addr.pop_front());
            void'(obs_wr_data.pop_front());
        end
        obs_wr_addr.delete();
        obs_wr_data.delete();
        exp_wr_addr.delete();
        exp_wr_data.delete();
    endtask

    task automatic run_op7(input int k, input logic [11:0] e_pc, input logic [11:0] e_ac,
                           input logic e_l, input string name);
        run_instr('0, op7(k), e_pc, e_ac, e_l, 2, name);
    endtask

    task automatic run_mri(input int k, input logic [11:0] ea, input logic [11:0] e_pc,
                           input logic [11:0] e_ac, input logic e_l, input int e_lat,
                           input string name);
        run_instr(mri(k, ea), '0, e_pc, e_ac, e_l, e_lat, name);
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (pc_value !== 12'o0200 || ac_out !== 12'o0 || link_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_regs got pc=%o ac=%o l=%0b want 0200/0000/0", pc_value, ac_out, link_out);
        end
        checks++;
        if ({dec_ready, exec_done, halted, illegal_op, rd_req, wr_req} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_outputs got %b want 100000",
                     {dec_ready, exec_done, halted, illegal_op, rd_req, wr_req});
        end
        reset_n = 1'b1;
    endtask

    task automatic test_tad;
        run_op7(K_CMA, 12'o0201, 12'o7777, 1'b0, "cma");
        mem[12'o0100] = 12'o0001;
        run_mri(M_TAD, 12'o0100, 12'o0202, 12'o0000, 1'b1, 3, "tad_carry");
    endtask

    task automatic test_and;
        mem[12'o0101] = 12'o0525;
        run_op7(K_CMA, 12'o0203, 12'o7777, 1'b1, "cma2");
        run_mri(M_AND, 12'o0101, 12'o0204, 12'o0525, 1'b1, 3, "and");
    endtask

    task automatic test_isz;
        mem[12'o0100] = 12'o7777;
        push_wr(12'o0100, 12'o0000);
        run_mri(M_ISZ, 12'o0100, 12'o0206, 12'o0525, 1'b1, 4, "isz_wrap");
        mem[12'o0102] = 12'o0005;
        push_wr(12'o0102, 12'o0006);
        run_mri(M_ISZ, 12'o0102, 12'o0207, 12'o0525, 1'b1, 4, "isz_plain");
        checks++;
        if (mem[12'o0100] !== 12'o0000) begin
            errors++;
            $display("FAIL isz_mem got %o want 0000", mem[12'o0100]);
        end
    endtask

    task automatic test_jms_dca;
        push_wr(12'o0300, 12'o0210);
        run_mri(M_JMS, 12'o0300, 12'o0301, 12'o0525, 1'b1, 2, "jms");
        run_op7(K_CLA1, 12'o0302, 12'o0000, 1'b1, "cla1");
        mem[12'o0110] = 12'o1234;
        run_mri(M_TAD, 12'o0110, 12'o0303, 12'o1234, 1'b1, 3, "tad_load");
        push_wr(12'o0050, 12'o1234);
        run_mri(M_DCA, 12'o0050, 12'o0304, 12'o0000, 1'b1, 2, "dca");
    endtask

    task automatic test_op7;
        run_op7(K_IAC, 12'o0305, 12'o0001, 1'b1, "iac");
        run_op7(K_RTR, 12'o0306, 12'o6000, 1'b0, "rtr");
        run_op7(K_CLA1, 12'o0307, 12'o0000, 1'b0, "cla1_b");
        run_op7(K_IAC, 12'o0310, 12'o0001, 1'b0, "iac_b");
        run_op7(K_CIA, 12'o0311, 12'o7777, 1'b0, "cia");
        run_op7(K_CLA2, 12'o0312, 12'o0000, 1'b0, "cla2");
        mem[12'o0111] = 12'o4000;
        run_mri(M_TAD, 12'o0111, 12'o0313, 12'o4000, 1'b0, 3, "tad_4000");
        run_op7(K_SMA, 12'o0315, 12'o4000, 1'b0, "sma_skip");
        run_op7(K_CLA1, 12'o0316, 12'o0000, 1'b0, "cla1_c");
        run_op7(K_IAC, 12'o0317, 12'o0001, 1'b0, "iac_c");
        run_op7(K_SZA, 12'o0320, 12'o0001, 1'b0, "sza_noskip");
        run_op7(K_CLA1, 12'o0321, 12'o0000, 1'b0, "cla1_d");
        run_op7(K_SZA, 12'o0323, 12'o0000, 1'b0, "sza_skip");
        run_op7(K_CML, 12'o0324, 12'o0000, 1'b1, "cml");
        run_op7(K_SNL, 12'o0326, 12'o0000, 1'b1, "snl_skip");
        run_op7(K_IAC, 12'o0327, 12'o0001, 1'b1, "iac_d");
        run_op7(K_RAL, 12'o0330, 12'o0003, 1'b0, "ral");
        run_op7(K_OSR, 12'o0331, 12'o0073, 1'b0, "osr");
        run_op7(K_CML, 12'o0332, 12'o0073, 1'b1, "cml_b");
        run_op7(K_CLL, 12'o0333, 12'o0166, 1'b0, "cll_ral");
        run_op7(K_CLA_CLL, 12'o0334, 12'o0000, 1'b0, "cla_cll");
        run_mri(M_JMP, 12'o7777, 12'o7777, 12'o0000, 1'b0, 2, "jmp_top");
        run_op7(K_IAC, 12'o0000, 12'o0001, 1'b0, "pc_wrap");
    endtask

    task automatic test_illegal;
        pdp_mem_opcode_s m;
        int ill0, rd0;
        m = mri(M_AND, 12'o0100);
        m.op_jmp = 1'b1;
        ill0 = illegal_cnt;
        rd0 = rd_cnt;
        run_instr(m, '0, 12'o0001, 12'o0001, 1'b0, 2, "illegal");
        checks++;
        if (illegal_cnt - ill0 != 1 || rd_cnt != rd0) begin
            errors++;
            $display("FAIL illegal_pulse got pulses=%0d reads=%0d want 1/0", illegal_cnt - ill0, rd_cnt - rd0);
        end
    endtask

    task automatic test_halt;
        bit bad;
        bit seen;
        @(negedge clk);
        op7_opcode = op7(K_HLT);
        dec_valid = 1'b1;
        @(negedge clk);
        dec_valid = 1'b0;
        op7_opcode = '0;
        @(negedge clk);
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (halted !== 1'b1 || dec_ready !== 1'b0 || exec_done !== 1'b0) bad = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL halt_hold got halted=%0b ready=%0b want 1/0", halted, dec_ready);
        end
        resume = 1'b1;
        @(negedge clk);
        resume = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (exec_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!seen || pc_value !== 12'o0002 || halted !== 1'b0 || dec_ready !== 1'b1) begin
            errors++;
            $display("FAIL resume got done=%0b pc=%o halted=%0b ready=%0b want 1/0002/0/1",
                     seen, pc_value, halted, dec_ready);
        end
        // resume outside HALTED has no effect
        @(negedge clk);
        resume = 1'b1;
        @(negedge clk);
        resume = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (exec_done !== 1'b0 || pc_value !== 12'o0002) bad = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL stray_resume got done=%0b pc=%o want 0/0002", exec_done, pc_value);
        end
    endtask

    task automatic test_back_to_back;
        run_op7(K_IAC, 12'o0003, 12'o0002, 1'b0, "b2b_1");
        run_op7(K_IAC, 12'o0004, 12'o0003, 1'b0, "b2b_2");
    endtask

    task automatic test_reset_mid;
        mem[12'o0100] = 12'o7777;
        @(negedge clk);
        mem_opcode = mri(M_ISZ, 12'o0100);
        dec_valid = 1'b1;
        @(negedge clk);
        dec_valid = 1'b0;
        mem_opcode = '0;
        @(negedge clk);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (pc_value !== 12'o0200 || ac_out !== 12'o0 || link_out !== 1'b0 || dec_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset got pc=%o ac=%o l=%0b ready=%0b want 0200/0000/0/1",
                     pc_value, ac_out, link_out, dec_ready);
        end
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (obs_wr_addr.size() != 0 || mem[12'o0100] !== 12'o7777) begin
            errors++;
            $display("FAIL mid_reset_write got writes=%0d mem=%o want 0/7777", obs_wr_addr.size(), mem[12'o0100]);
        end
        run_op7(K_IAC, 12'o0201, 12'o0001, 1'b0, "after_reset");
        mem[12'o0120] = 12'o0007;
        run_mri(M_TAD, 12'o0120, 12'o0202, 12'o0010, 1'b0, 3, "after_reset_tad");
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = '0;
        test_reset();
        test_tad();
        test_and();
        test_isz();
        test_jms_dca();
        test_op7();
        test_illegal();
        test_halt();
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (conflicts != 0) begin
            errors++;
            $display("FAIL rd_wr_overlap got %0d want 0", conflicts);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pdp8_instr_exec.md
Name: pdp8_instr_exec

Overview:
- Execute stage of the PDP-8 ISA-level model; sits downstream of the instruction decoder, which produces the decoded MRI and op7 opcode structs from the shared package.
- Accepts one decoded instruction per valid/ready handshake, reads and writes memory over a simple request interface, and updates AC, Link and PC.
- Returns the next PC to the decoder with a one-cycle done pulse.

Parameters:
- START_ADDR, 12'o0200: PC value at reset.
- AW, 12: address width.
- DW, 12: data width.

Ports:
- clk in 1: clock.
- reset_n in 1: asynchronous reset, active low.
- dec_valid in 1: decoded instruction present.
- dec_ready out 1: exec able to accept an instruction.
- mem_opcode in pdp_mem_opcode_s: MRI one-hot bits plus effective address. Indirection is already resolved by the decoder.
- op7_opcode in pdp_op7_opcode_s: op7 one-hot bits.
- switch_reg in 12: console switches, used by OSR.
- resume in 1: leave halt.
- rd_req out 1: memory read request.
- rd_addr out 12: read address.
- rd_data in 12: read data, valid the cycle after rd_req.
- wr_req out 1: memory write, committed at the same clock edge.
- wr_addr out 12: write address.
- wr_data out 12: write data.
- pc_value out 12: current PC.
- exec_done out 1: one-cycle pulse; pc_value is the next PC.
- ac_out out 12: accumulator.
- link_out out 1: Link.
- halted out 1: processor halted.
- illegal_op out 1: one-cycle pulse, more than one opcode bit set.

Behaviour:
- Reset (asynchronous, any state):
  - State = IDLE, PC = START_ADDR, AC = 0, L = 0.
  - All outputs 0, except dec_ready = 1 and pc_value = START_ADDR.
  - Any in-flight read or write is dropped; no wr_req is issued after reset.
- States: IDLE, EXEC, RD, RD_WAIT, WR, HALTED, DONE.
- IDLE:
  - dec_ready = 1.
  - On dec_valid, capture both structs and dec_ready drops the next cycle.
  - dec_valid while dec_ready = 0 is ignored; the decoder holds its outputs.
- Opcode legality:
  - Zero opcode bits set: NOP.
  - More than one bit set across both structs: illegal_op pulses in EXEC and the instruction executes as NOP.
- Routing out of IDLE:
  - AND, TAD, ISZ go to RD. RD asserts rd_req with rd_addr = EA, then goes to RD_WAIT.
  - RD_WAIT samples rd_data. AND: AC &= M. TAD: {c,AC} = AC + M, and L ^= c. Both then go to DONE.
  - ISZ in RD_WAIT: tmp = M + 1 (mod 4096), go to WR writing tmp at EA; skip if tmp == 0.
  - DCA goes to WR: write AC at EA, then AC = 0.
  - JMS goes to WR: write PC+1 at EA, then next PC = EA+1.
  - JMP, and all op7 instructions, go to EXEC (one cycle), then DONE. JMP sets next PC = EA.
- op7 operations (13-bit {L,AC} for rotates):
  - IAC: {L,AC} carry: AC+1, L ^= carry.
  - RAL / RTL: rotate left 1 / 2.
  - RAR / RTR: rotate right 1 / 2.
  - CML: L = ~L.
  - CMA: AC = ~AC.
  - CIA: AC = ~AC + 1, L ^= carry.
  - CLL (7104): L = 0, then RAL.
  - CLA1, CLA2: AC = 0.
  - CLA_CLL: AC = 0, L = 0.
  - OSR: AC |= switch_reg.
  - Skips: SKP always; SNL if L; SZL if !L; SZA if AC == 0; SNA if AC != 0; SMA if AC[11]; SPA if !AC[11]. Skip tests use the pre-instruction values.
  - HLT goes to HALTED.
- Next PC:
  - Default PC+1; PC+2 on skip.
  - JMP and JMS as above.
  - All arithmetic is mod 4096; 7777 wraps to 0000.
- HALTED:
  - halted = 1, dec_ready = 0.
  - On resume, clear halted and go to DONE with PC+1.
  - resume outside HALTED is ignored.
- DONE:
  - exec_done = 1 for one cycle; PC register updated at the same edge, so pc_value shows the new PC together with done.
  - Return to IDLE.
- Latency, accept edge to exec_done:
  - op7 and JMP: 2 cycles.
  - DCA and JMS: 2 cycles.
  - AND and TAD: 3 cycles.
  - ISZ: 4 cycles.
- rd_req and wr_req are never asserted in the same cycle.

Decomposition:
- Add to pdp8_pkg:
  - exec_state_e enum.
  - The `define opcode constants already there, reused.
- Sub-module pdp8_op7_alu, purely combinational.
  - Inputs: op7 struct, AC, L, switch_reg.
  - Outputs: new AC, new L, skip, halt.
- The FSM, registers and memory sequencing stay in pdp8_instr_exec.

Test Plan:
1. TAD: AC=7777, L=0, EA=0100, mem[0100]=0001 -> AC=0000, L=1, pc_value 0200->0201, exec_done 3 cycles after accept.
2. ISZ: EA=0100, mem=7777 -> wr_req with wr_addr=0100, wr_data=0000; next PC=0202. Also mem=0005 -> write 0006, PC=0201.
3. JMS: PC=0200, EA=0300 -> write 0201 at 0300; PC=0301. Then DCA with AC=1234, EA=0050 -> wr_data=1234, AC=0000.
4. op7 rotates and skips:
   - L=1, AC=0001, RTR -> L=0, AC=6000.
   - CIA on 0001 -> AC=7777.
   - SMA with AC=4000 -> PC+2.
   - SZA with AC=0001 -> PC+1.
5. HLT and illegal:
   - HLT -> halted=1, dec_ready=0 held 10 cycles; resume -> exec_done, PC+1, dec_ready=1.
   - Both AND and JMP set -> illegal_op pulse, AC unchanged, PC+1.
6. Reset mid-operation:
   - Deassert reset_n during ISZ RD_WAIT -> no wr_req ever issued; PC=0200, AC=0, L=0, dec_ready=1.
   - After release, the next instruction executes normally.
